// File: rtl/uart_host_controller.sv
// Sensor-side UART frame reassembler and host-side command serialiser.
// The RX and TX paths share only the clock and reset.
module uart_host_controller #(
  parameter logic [15:0] TIMEOUT_CLKS = 16'd50000
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [7:0]  i_RX_BYTE,
  input  logic        i_RX_BYTE_VALID,
  output logic [39:0] o_FRAME_DATA,
  output logic        o_FRAME_VALID,
  input  logic        i_FRAME_READY,
  output logic        o_FRAME_ERR,
  output logic        o_OVERFLOW,
  input  logic [15:0] i_CMD,
  input  logic        i_CMD_VALID,
  output logic        o_CMD_READY,
  output logic        o_CMD_ERR,
  output logic [7:0]  o_TX_BYTE,
  output logic        o_TX_BYTE_VALID,
  input  logic        i_TX_BYTE_DONE
);

  typedef enum logic {RIdle, RPayload} rx_state_e;
  typedef enum logic [1:0] {TIdle, TSend, TWait} tx_state_e;

  rx_state_e   rx_state_q;
  logic [39:0] shift_q;
  logic [1:0]  byte_cnt_q;
  logic [1:0]  last_idx_q;
  logic [15:0] timer_q;

  tx_state_e   tx_state_q;
  logic [15:0] cmd_q;
  logic        two_byte_q;

  logic        hdr_known;
  logic [1:0]  hdr_last;
  logic [39:0] frame_next;
  logic [15:0] timer_inc;
  logic        cmd_ok;
  logic        cmd_two;

  // Header decode: hdr_last is the index of the final payload byte.
  always_comb begin
    hdr_known = 1'b1;
    hdr_last  = 2'd0;
    case (i_RX_BYTE)
      8'hAA:                hdr_last = 2'd3;
      8'hBB, 8'h61, 8'h6D:  hdr_last = 2'd1;
      default:              hdr_known = 1'b0;
    endcase
  end

  always_comb begin
    frame_next = shift_q;
    unique case (byte_cnt_q)
      2'd0: frame_next[31:24] = i_RX_BYTE;
      2'd1: frame_next[23:16] = i_RX_BYTE;
      2'd2: frame_next[15:8]  = i_RX_BYTE;
      2'd3: frame_next[7:0]   = i_RX_BYTE;
    endcase
  end

  assign timer_inc = timer_q + 16'd1;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      rx_state_q    <= RIdle;
      shift_q       <= '0;
      byte_cnt_q    <= '0;
      last_idx_q    <= '0;
      timer_q       <= '0;
      o_FRAME_DATA  <= '0;
      o_FRAME_VALID <= 1'b0;
      o_FRAME_ERR   <= 1'b0;
      o_OVERFLOW    <= 1'b0;
    end else begin
      o_FRAME_ERR <= 1'b0;
      o_OVERFLOW  <= 1'b0;
      if (o_FRAME_VALID && i_FRAME_READY) o_FRAME_VALID <= 1'b0;
      case (rx_state_q)
        RIdle: begin
          if (i_RX_BYTE_VALID) begin
            if (hdr_known) begin
              // Clearing the low lanes here gives the zero fill of short frames.
              shift_q    <= {i_RX_BYTE, 32'h0};
              byte_cnt_q <= '0;
              timer_q    <= '0;
              last_idx_q <= hdr_last;
              rx_state_q <= RPayload;
            end else begin
              o_FRAME_ERR <= 1'b1;
            end
          end
        end
        RPayload: begin
          if (i_RX_BYTE_VALID) begin
            shift_q    <= frame_next;
            byte_cnt_q <= byte_cnt_q + 2'd1;
            timer_q    <= '0;
            if (byte_cnt_q == last_idx_q) begin
              rx_state_q <= RIdle;
              // A consumer accepting this cycle frees the slot for the new frame.
              if (!o_FRAME_VALID || i_FRAME_READY) begin
                o_FRAME_DATA  <= frame_next;
                o_FRAME_VALID <= 1'b1;
              end else begin
                o_OVERFLOW <= 1'b1;
              end
            end
          end else if (timer_inc == TIMEOUT_CLKS) begin
            o_FRAME_ERR <= 1'b1;
            timer_q     <= '0;
            rx_state_q  <= RIdle;
          end else begin
            timer_q <= timer_inc;
          end
        end
      endcase
    end
  end

  always_comb begin
    cmd_ok  = 1'b1;
    cmd_two = 1'b0;
    case (i_CMD[15:8])
      8'h52, 8'h53, 8'h46, 8'h66: cmd_two = 1'b0;
      8'h61, 8'h6D:               cmd_two = 1'b1;
      default:                    cmd_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      tx_state_q      <= TIdle;
      cmd_q           <= '0;
      two_byte_q      <= 1'b0;
      o_CMD_READY     <= 1'b0;
      o_CMD_ERR       <= 1'b0;
      o_TX_BYTE       <= '0;
      o_TX_BYTE_VALID <= 1'b0;
    end else begin
      o_CMD_ERR <= 1'b0;
      case (tx_state_q)
        TIdle: begin
          o_CMD_READY <= 1'b1;
          if (i_CMD_VALID && o_CMD_READY) begin
            cmd_q <= i_CMD;
            if (cmd_ok) begin
              // First byte is launched on entry so the strobe coincides with TSend.
              two_byte_q      <= cmd_two;
              o_TX_BYTE       <= i_CMD[15:8];
              o_TX_BYTE_VALID <= 1'b1;
              o_CMD_READY     <= 1'b0;
              tx_state_q      <= TSend;
            end else begin
              o_CMD_ERR <= 1'b1;
            end
          end
        end
        TSend: begin
          o_TX_BYTE_VALID <= 1'b0;
          tx_state_q      <= TWait;
        end
        TWait: begin
          if (i_TX_BYTE_DONE) begin
            if (two_byte_q) begin
              two_byte_q      <= 1'b0;
              o_TX_BYTE       <= cmd_q[7:0];
              o_TX_BYTE_VALID <= 1'b1;
              tx_state_q      <= TSend;
            end else begin
              o_CMD_READY <= 1'b1;
              tx_state_q  <= TIdle;
            end
          end
        end
        default: tx_state_q <= TIdle;
      endcase
    end
  end

endmodule
